add_result_stage: RTL

- Registered output stage that sits directly downstream of the 32-bit carry-bypass adder.
- Captures each adder result (r, cout, overflow) together with a valid strobe into a 2-entry buffer, and derives zero/negative flags.
- Presents results to the consumer over a valid/ready handshake.
- Keeps a saturating count of signed-overflow results for debug.

---
 rtl/add_result_stage.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/add_result_stage.sv
// ---------------------------------------------------------------------------
// add_result_stage
//
// Registered output stage placed after the 32-bit carry-bypass adder. Each
// accepted adder result (sum, carry, signed overflow) is held in a 2-entry
// FIFO together with precomputed zero/negative flags. The stored results are
// offered to the consumer through a valid/ready handshake. A saturating
// counter records how many accepted beats had signed overflow.
//
// Optional feature macro: ADD_RESULT_SAT_EN
//   defined   - a beat with in_ovf=1 stores a saturated result (max positive
//               when the wrapped sum looks negative, min negative otherwise).
//   undefined - the wrapped two's-complement sum is stored unmodified.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream result valid
//   in_ready   out  stage can accept a beat (registered)
//   in_r       in   adder sum [WIDTH]
//   in_cout    in   adder carry out
//   in_ovf     in   adder signed overflow
//   out_valid  out  head entry valid (registered)
//   out_ready  in   consumer accepts head entry
//   out_result out  head result [WIDTH]
//   out_cout   out  head carry (raw)
//   out_ovf    out  head signed overflow (raw)
//   out_zero   out  head result == 0
//   out_neg    out  head result sign bit
//   ovf_cnt    out  saturating count of accepted overflow beats [CNT_W]
//   cnt_clr    in   synchronous clear of ovf_cnt (beats a same-cycle increment)
// ---------------------------------------------------------------------------
module add_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_r,
    input  logic             in_cout,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             cnt_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic in_ready_q;
    logic out_valid_q;

    // Head entry drives the outputs directly; tail holds the second beat.
    logic [WIDTH-1:0] head_res_q, tail_res_q;
    logic             head_cout_q, tail_cout_q;
    logic             head_ovf_q, tail_ovf_q;
    logic             head_zero_q, tail_zero_q;
    logic             head_neg_q, tail_neg_q;

    logic [CNT_W-1:0] cnt_q;

    logic push;
    logic pop;
    logic load_head;   // incoming beat goes straight to head
    logic load_tail;   // incoming beat parks in tail
    logic shift_tail;  // tail moves up to head

    // Value actually stored for the incoming beat, plus its flags.
    logic [WIDTH-1:0] new_res;
    logic             new_zero;
    logic             new_neg;

`ifdef ADD_RESULT_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // On signed overflow the wrapped sign is the opposite of the true sign:
    // a wrapped negative means the true result was too large positive.
    always_comb begin
        new_res = in_r;
        if (in_ovf) begin
            new_res = in_r[WIDTH-1] ? SAT_MAX : SAT_MIN;
        end
    end
`else
    always_comb begin
        new_res = in_r;
    end
`endif

    assign new_zero = (new_res == '0);
    assign new_neg  = new_res[WIDTH-1];

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // ---------------- buffer occupancy FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift_tail = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d   = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d   = TWO;
                    load_tail = 1'b1;
                end else if (pop && !push) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    load_head = 1'b1;
                end
            end
            TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_d    = ONE;
                    shift_tail = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Handshake strobes are registered from the next state so neither
    // depends combinationally on the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // ---------------- entry storage ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_res_q  <= '0;
            head_cout_q <= 1'b0;
            head_ovf_q  <= 1'b0;
            head_zero_q <= 1'b1;
            head_neg_q  <= 1'b0;
        end else if (load_head) begin
            head_res_q  <= new_res;
            head_cout_q <= in_cout;
            head_ovf_q  <= in_ovf;
            head_zero_q <= new_zero;
            head_neg_q  <= new_neg;
        end else if (shift_tail) begin
            head_res_q  <= tail_res_q;
            head_cout_q <= tail_cout_q;
            head_ovf_q  <= tail_ovf_q;
            head_zero_q <= tail_zero_q;
            head_neg_q  <= tail_neg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_res_q  <= '0;
            tail_cout_q <= 1'b0;
            tail_ovf_q  <= 1'b0;
            tail_zero_q <= 1'b1;
            tail_neg_q  <= 1'b0;
        end else if (load_tail) begin
            tail_res_q  <= new_res;
            tail_cout_q <= in_cout;
            tail_ovf_q  <= in_ovf;
            tail_zero_q <= new_zero;
            tail_neg_q  <= new_neg;
        end
    end

    // ---------------- overflow event counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (push && in_ovf && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = head_res_q;
    assign out_cout   = head_cout_q;
    assign out_ovf    = head_ovf_q;
    assign out_zero   = head_zero_q;
    assign out_neg    = head_neg_q;
    assign ovf_cnt    = cnt_q;

endmodule
